// File: rtl/instr_encoder.sv
// RV32I instruction encoder: range-checks and scatters an immediate into an
// instruction word, expanding li into LUI (+ ADDI) with valid/ready on both sides.
module instr_encoder (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic        o_last,
  output logic        o_err
);

  typedef enum logic [1:0] {IDLE, OUT, OUT_HI} state_t;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM = 7'b0010011;
  localparam logic [6:0]  OP_LUI = 7'b0110111;

  // True when v is representable as a two's-complement value of the given width.
  function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned bits);
    logic signed [31:0] lim;
    lim = 32'sd1 <<< (bits - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  state_t             state_q, state_d;
  logic signed [31:0] imm_s;
  logic [19:0]        li_hi;
  logic               is_shift;
  logic [31:0]        enc_word, enc_addi, addi_q;
  logic               enc_err, enc_two;
  logic               accept, consume;

  assign imm_s    = i_imm;
  // (v + 0x800) >> 12: the low-half add only carries into bit 12 when v[11] is set.
  assign li_hi    = i_imm[31:12] + {19'd0, i_imm[11]};
  assign is_shift = (i_opcode == OP_IMM) && (i_funct3[1:0] == 2'b01);

  assign o_req_ready = !o_instr_valid || (i_instr_ready && o_last);
  assign accept      = i_req_valid && o_req_ready;
  assign consume     = o_instr_valid && i_instr_ready;

  always_comb begin
    enc_word = '0;
    enc_addi = '0;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    case (i_fmt)
      3'd0: enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      3'd1: begin
        if (is_shift) begin
          enc_err  = |i_imm[31:5];
          enc_word = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
        end else begin
          enc_err  = !fits_signed(imm_s, 12);
          enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        end
      end
      3'd2: begin
        enc_err  = !fits_signed(imm_s, 12);
        enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      end
      3'd3: begin
        enc_err  = !fits_signed(imm_s, 13) || i_imm[0];
        enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                    i_imm[4:1], i_imm[11], i_opcode};
      end
      3'd4: begin
        enc_err  = |i_imm[11:0];
        enc_word = {i_imm[31:12], i_rd, i_opcode};
      end
      3'd5: begin
        enc_err  = !fits_signed(imm_s, 21) || i_imm[0];
        enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      end
      3'd6: begin
        if (fits_signed(imm_s, 12)) begin
          enc_word = {i_imm[11:0], 5'd0, 3'b000, i_rd, OP_IMM};
        end else begin
          enc_word = {li_hi, i_rd, OP_LUI};
          enc_two  = |i_imm[11:0];
          enc_addi = {i_imm[11:0], i_rd, 3'b000, i_rd, OP_IMM};
        end
      end
      default: enc_err = 1'b1;
    endcase
    if (enc_err) enc_word = NOP;
  end

  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = enc_two ? OUT_HI : OUT;
    else if (consume)
      state_d = (state_q == OUT_HI) ? OUT : IDLE;
  end

  // Output register stage: loads a new request, or advances LUI -> ADDI.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      o_instr_valid <= 1'b0;
      o_instr       <= '0;
      o_last        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_instr_valid <= (state_d != IDLE);
      if (accept) begin
        o_instr <= enc_word;
        o_last  <= !enc_two;
        o_err   <= enc_err;
      end else if (consume && state_q == OUT_HI) begin
        o_instr <= addi_q;
        o_last  <= 1'b1;
        o_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) addi_q <= enc_addi;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [2:0]  i_fmt = '0;
  logic [6:0]  i_opcode = '0;
  logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic [2:0]  i_funct3 = '0;
  logic [6:0]  i_funct7 = '0;
  logic [31:0] i_imm = '0;
  logic        o_instr_valid;
  logic        i_instr_ready = 1'b1;
  logic [31:0] o_instr;
  logic        o_last;
  logic        o_err;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_fmt(i_fmt), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_instr_valid(o_instr_valid), .i_instr_ready(i_instr_ready),
    .o_instr(o_instr), .o_last(o_last), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] imm);
    i_fmt = fmt; i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_funct3 = f3; i_funct7 = f7; i_imm = imm;
  endtask

  // Present a request, wait (bounded) for acceptance, return 1 time unit after that edge.
  task automatic do_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
    int n;
    @(negedge i_clk);
    set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
    i_req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_req_ready) begin
      vectors++;
      miscompares++;
      $error("FAIL req_timeout: observed ready %b expected 1", o_req_ready);
    end
    step();
    i_req_valid = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] instr, input logic last,
                          input logic err);
    chk({tag, "_valid"}, {31'd0, o_instr_valid}, 32'd1);
    chk({tag, "_instr"}, o_instr, instr);
    chk({tag, "_last"}, {31'd0, o_last}, {31'd0, last});
    chk({tag, "_err"}, {31'd0, o_err}, {31'd0, err});
  endtask

  logic [31:0] held;
  logic [31:0] b2b_exp [3];

  initial begin
    // Reset state
    repeat (2) step();
    i_rst = 1'b0;
    chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_last", {31'd0, o_last}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);

    // add x3,x1,x2
    do_req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    chk_word("add", 32'h002081B3, 1'b1, 1'b0);
    step();
    chk("add_drain", {31'd0, o_instr_valid}, 32'd0);

    // Branches
    do_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4);
    chk_word("beq_m4", 32'hFE208EE3, 1'b1, 1'b0);
    do_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd2);
    chk_word("beq_2", 32'h00208163, 1'b1, 1'b0);
    do_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    chk_word("beq_odd", 32'h00000013, 1'b1, 1'b1);

    // I-type / shifts
    do_req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h800);
    chk_word("addi_800", 32'h00000013, 1'b1, 1'b1);
    do_req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32);
    chk_word("slli_32", 32'h00000013, 1'b1, 1'b1);
    do_req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd31);
    chk_word("slli_31", 32'h01F09093, 1'b1, 1'b0);

    // S, U, J, reserved
    do_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    chk_word("sw", 32'h0020A423, 1'b1, 1'b0);
    do_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    chk_word("lui", 32'h123452B7, 1'b1, 1'b0);
    do_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
    chk_word("lui_bad", 32'h00000013, 1'b1, 1'b1);
    do_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    chk_word("jal", 32'h008000EF, 1'b1, 1'b0);
    do_req(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    chk_word("fmt7", 32'h00000013, 1'b1, 1'b1);

    // Two-word LI; fields scrambled after acceptance must not matter
    do_req(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    set_fields(3'd0, 7'h7F, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'd0);
    chk_word("li2_lui", 32'h123462B7, 1'b0, 1'b0);
    chk("li2_ready_lo", {31'd0, o_req_ready}, 32'd0);
    step();
    chk_word("li2_addi", 32'hFFF28293, 1'b1, 1'b0);
    step();
    chk("li2_drain", {31'd0, o_instr_valid}, 32'd0);

    // Single-word LI forms
    do_req(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00010000);
    chk_word("li_lui_only", 32'h000102B7, 1'b1, 1'b0);
    do_req(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd5);
    chk_word("li_neg5", 32'hFFB00293, 1'b1, 1'b0);
    step();

    // Backpressure: word holds for 3 cycles
    i_instr_ready = 1'b0;
    do_req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    held = o_instr;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_word("bp_hold", 32'h002081B3, 1'b1, 1'b0);
      chk("bp_stable", o_instr, held);
      chk("bp_ready", {31'd0, o_req_ready}, 32'd0);
    end
    i_instr_ready = 1'b1;
    step();
    chk("bp_drain", {31'd0, o_instr_valid}, 32'd0);

    // Back-to-back single-word requests, one per cycle
    b2b_exp[0] = 32'h002081B3;   // add x3,x1,x2
    b2b_exp[1] = 32'h40208233;   // sub x4,x1,x2
    b2b_exp[2] = 32'h0020F2B3;   // and x5,x1,x2
    @(negedge i_clk);
    i_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_fields(3'd0, 7'h33, 5'(3 + k), 5'd1, 5'd2, (k == 2) ? 3'd7 : 3'd0,
                 (k == 1) ? 7'h20 : 7'd0, 32'd0);
      step();
      chk_word("b2b", b2b_exp[k], 1'b1, 1'b0);
      chk("b2b_ready", {31'd0, o_req_ready}, 32'd1);
    end
    i_req_valid = 1'b0;
    step();
    chk("b2b_drain", {31'd0, o_instr_valid}, 32'd0);

    // Reset while LUI of a two-word LI is held
    do_req(3'd6, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
    chk_word("rst_hi_lui", 32'h123462B7, 1'b0, 1'b0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rst_hi_valid", {31'd0, o_instr_valid}, 32'd0);
    chk("rst_hi_ready", {31'd0, o_req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_hi_no_addi", {31'd0, o_instr_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V RV32I instruction encoder: the inverse of the core's immediate decode path. It accepts decoded fields plus a 32-bit immediate, range-checks the immediate for the requested format, and scatters it into a 32-bit instruction word. It also expands an `li` pseudo-op into LUI/ADDI. It sits between the debug/boot program-buffer sequencer (upstream) and the instruction memory writer (downstream), with valid/ready on both sides.

## Interface
- No parameters.
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_req_valid` in 1: request valid.
- `o_req_ready` out 1: request accepted when both valid and ready are high.
- `i_fmt` in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI; 7 is reserved and encodes as an error.
- `i_opcode` in 7: opcode bits [6:0]; ignored for LI.
- `i_rd`, `i_rs1`, `i_rs2` in 5 each: register fields.
- `i_funct3` in 3, `i_funct7` in 7: function fields.
- `i_imm` in 32: full signed immediate. For U, this is the final value; bits [11:0] must be 0.
- `o_instr_valid` out 1: output word valid.
- `i_instr_ready` in 1: downstream accepts the word.
- `o_instr` out 32: encoded instruction.
- `o_last` out 1: last word of the current request.
- `o_err` out 1: immediate out of range or reserved format; the word is a NOP.

## Operation
- States:
  - IDLE: no word held.
  - OUT: final word held.
  - OUT_HI: LUI held, ADDI pending.
- `o_req_ready` = `!o_instr_valid || (i_instr_ready && o_last)`. This gives full throughput: one request per cycle for single-word requests.
- Encoding:
  - R: `{funct7, rs2, rs1, funct3, rd, opcode}`.
  - I: `{imm[11:0], rs1, funct3, rd, opcode}`.
  - I with opcode 0010011 and funct3 001/101 (shift): `{funct7, imm[4:0], rs1, funct3, rd, opcode}`.
  - S: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B: `{imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}`.
  - U: `{imm[31:12], rd, opcode}`.
  - J: `{imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}`.
- Range checks; any failure sets `o_err`:
  - I/S: `imm[31:11]` all equal.
  - Shift: `imm[31:5]` == 0.
  - B: `imm[31:12]` all equal and `imm[0]` == 0.
  - J: `imm[31:20]` all equal and `imm[0]` == 0.
  - U: `imm[11:0]` == 0.
  - R: never errors.
- On error: `o_instr` = 0x00000013 (NOP), `o_err` = 1, `o_last` = 1. Exactly one word is emitted.
- LI (value v = `i_imm`, target `i_rd`):
  - If `v[31:11]` are all equal: one word, ADDI rd,x0,v[11:0].
  - Otherwise: hi = `(v + 32'h800) >> 12`, computed mod 2^32, 20 bits; lo = `v[11:0]`.
  - Emit LUI rd,hi (opcode 0110111). If lo ≠ 0, follow with ADDI rd,rd,lo (opcode 0010011, funct3 000).
  - If lo = 0, LUI is the only word and `o_last` = 1.
- `o_last` = 0 only on the LUI of a two-word LI.
- `o_err` is valid only with `o_instr_valid`. It is 0 for every LI.
- Request fields are sampled at acceptance. Input changes afterwards have no effect.

## Timing
- Reset values: `o_instr_valid` = 0, `o_instr` = 0, `o_last` = 0, `o_err` = 0, state = IDLE. `o_req_ready` = 1 in the cycle after reset.
- All outputs except `o_req_ready` are registered.
- Latency: a request accepted at edge N gives `o_instr_valid` = 1 from cycle N+1.
- Two-word LI:
  - LUI is presented from cycle N+1.
  - When it is accepted, ADDI appears in the next cycle.
  - `o_req_ready` = 0 while OUT_HI holds.
- Backpressure: while `o_instr_valid` && `!i_instr_ready`, `o_instr`, `o_last` and `o_err` hold stable.
- Simultaneous final-word consume and new request: the new word loads in the same edge, with no bubble.
- Reset mid-operation, including OUT_HI: the pending word is discarded, the ADDI is never emitted, and the block returns to IDLE.

## Test plan
- R-type add x3,x1,x2 (fmt 0, opcode 0x33, funct3 0, funct7 0) -> `o_instr` = 0x002081B3, `o_last` = 1, `o_err` = 0, valid one cycle after acceptance.
- B-type beq x1,x2 with imm = -4 (opcode 0x63) -> 0xFE208EE3. Same request with imm = 2 (bit 0 clear, in range) -> no error. With imm = 3 -> `o_err` = 1, `o_instr` = 0x00000013.
- LI x5, 0x12345FFF -> 0x123462B7 (`o_last` = 0), then 0xFFF28293 (`o_last` = 1). `o_req_ready` = 0 between the two words.
- LI x5, 0x00010000 -> single 0x000102B7, `o_last` = 1. LI x5, -5 -> single 0xFFB00293.
- I-type imm 0x800 -> `o_err` = 1, NOP. Shift slli (funct3 001) with imm 32 -> `o_err` = 1. Slli with imm 31, rd = rs1 = 1 -> 0x01F09093.
- Backpressure and reset: hold `i_instr_ready` = 0 for 3 cycles -> word stable. Back-to-back single-word requests with ready = 1 -> one word per cycle. Assert `i_rst` while in OUT_HI -> next cycle `o_instr_valid` = 0, `o_req_ready` = 1, no ADDI emitted.
